// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester memory port arbiter with MRDY watchdog
// Define ARB_FIXED_PRIO_EN to give port 1 (data side) absolute priority on ties.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          REQ0,
  input  logic          REQ1,
  input  logic          WE0,
  input  logic          WE1,
  input  logic [AW-1:0] ADDR0,
  input  logic [AW-1:0] ADDR1,
  input  logic [DW-1:0] WDATA0,
  input  logic [DW-1:0] WDATA1,
  output logic [DW-1:0] RDATA0,
  output logic [DW-1:0] RDATA1,
  output logic          ACK0,
  output logic          ACK1,
  output logic          ERR0,
  output logic          ERR1,
  output logic [AW-1:0] MADDR,
  output logic          MWE,
  output logic [DW-1:0] MWDATA,
  output logic          MSTART,
  input  logic [DW-1:0] MRDATA,
  input  logic          MRDY,
  output logic          BUSY
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state_q;
  logic          last_q;
  logic          gnt_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [AW-1:0] maddr_q;
  logic [DW-1:0] mwdata_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;
  logic          mwe_q;
  logic          mstart_q;
  logic          ack0_q;
  logic          ack1_q;
  logic          err0_q;
  logic          err1_q;
  logic          busy_q;
  logic          pick;

  // pick is only meaningful when at least one REQ is high
  always_comb begin
    pick = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    pick = REQ1;
`else
    if (REQ0 && REQ1) begin
      pick = ~last_q;
    end else begin
      pick = REQ1;
    end
`endif
  end

  assign cnt_d = cnt_q + CW'(1);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      cnt_q    <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      mwe_q    <= 1'b0;
      mstart_q <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (REQ0 || REQ1) begin
            gnt_q    <= pick;
            maddr_q  <= pick ? ADDR1 : ADDR0;
            mwe_q    <= pick ? WE1 : WE0;
            mwdata_q <= pick ? WDATA1 : WDATA0;
            busy_q   <= 1'b1;
            mstart_q <= 1'b1;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          mstart_q <= 1'b0;
          cnt_q    <= '0;
          state_q  <= WAIT;
        end
        WAIT: begin
          // MRDY takes precedence over a watchdog expiry in the same cycle
          if (MRDY) begin
            if (!mwe_q) begin
              if (gnt_q) begin
                rdata1_q <= MRDATA;
              end else begin
                rdata0_q <= MRDATA;
              end
            end
            ack0_q  <= ~gnt_q;
            ack1_q  <= gnt_q;
            state_q <= DONE;
          end else if (cnt_d == TO_VAL) begin
            ack0_q  <= ~gnt_q;
            ack1_q  <= gnt_q;
            err0_q  <= ~gnt_q;
            err1_q  <= gnt_q;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          err0_q  <= 1'b0;
          err1_q  <= 1'b0;
          mwe_q   <= 1'b0;
          busy_q  <= 1'b0;
          last_q  <= gnt_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign RDATA0 = rdata0_q;
  assign RDATA1 = rdata1_q;
  assign ACK0   = ack0_q;
  assign ACK1   = ack1_q;
  assign ERR0   = err0_q;
  assign ERR1   = err1_q;
  assign MADDR  = maddr_q;
  assign MWE    = mwe_q;
  assign MWDATA = mwdata_q;
  assign MSTART = mstart_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
// Expected grant order follows ARB_FIXED_PRIO_EN when it is defined.
module tb_mem_port_arbiter;

  localparam int TO = 8;
  localparam logic [31:0] KEY = 32'h5A5A_A5A5;

  logic        CLK = 1'b0;
  logic        RST_N, REQ0, REQ1, WE0, WE1, MRDY;
  logic [31:0] ADDR0, ADDR1, WDATA0, WDATA1, MRDATA;
  logic [31:0] RDATA0, RDATA1, MADDR, MWDATA;
  logic        ACK0, ACK1, ERR0, ERR1, MWE, MSTART, BUSY;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .RDATA0(RDATA0), .RDATA1(RDATA1), .ACK0(ACK0), .ACK1(ACK1), .ERR0(ERR0), .ERR1(ERR1),
    .MADDR(MADDR), .MWE(MWE), .MWDATA(MWDATA), .MSTART(MSTART),
    .MRDATA(MRDATA), .MRDY(MRDY), .BUSY(BUSY)
  );

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] rd0;
    logic [31:0] rd1;
    int          lat;
  } ack_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } st_t;

  ack_t ack_q[$];
  st_t  st_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   mstart_cyc = 0;
  int   last_ack_cyc = -1;
  logic [31:0] m_rd0 = '0;
  logic [31:0] m_rd1 = '0;

  int          mem_delay = 1;
  int          mem_cnt = -1;
  logic        mem_ovr = 1'b0;
  logic [31:0] mem_ovr_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge CLK) cyc++;

  // memory model: one-cycle MRDY in the mem_delay-th cycle after the MSTART cycle
  always @(negedge CLK) begin
    MRDY   = 1'b0;
    MRDATA = 32'h0BAD_0BAD;
    if (MSTART) mem_cnt = 0;
    else if (mem_cnt >= 0) mem_cnt++;
    if (mem_cnt >= 1 && mem_cnt == mem_delay) begin
      MRDY    = 1'b1;
      MRDATA  = mem_ovr ? mem_ovr_data : (MADDR ^ KEY);
      mem_cnt = -1;
    end
  end

  always @(negedge CLK) begin
    st_t  s;
    ack_t a;
    if (MSTART) begin
      mstart_cyc = cyc;
      if (last_ack_cyc >= 0) check("grant_gap_ge_2", (cyc - last_ack_cyc) >= 2, 1);
      if (st_q.size() == 0) begin
        check("unexpected_mstart", 1, 0);
      end else begin
        s = st_q.pop_front();
        check("maddr", MADDR, s.addr);
        check("mwe", MWE, s.we);
        check("mwdata", MWDATA, s.wdata);
        check("busy_at_start", BUSY, 1);
      end
    end
    if (ACK0 || ACK1) begin
      last_ack_cyc = cyc;
      if (ack_q.size() == 0) begin
        check("unexpected_ack", {ACK1, ACK0}, 0);
      end else begin
        a = ack_q.pop_front();
        check("ack_port", {ACK1, ACK0}, (a.port != 0) ? 2'b10 : 2'b01);
        check("err", {ERR1, ERR0}, a.err ? ((a.port != 0) ? 2'b10 : 2'b01) : 2'b00);
        check("rdata0", RDATA0, a.rd0);
        check("rdata1", RDATA1, a.rd1);
        check("busy_at_ack", BUSY, 1);
        check("ack_latency", cyc - mstart_cyc, a.lat);
      end
    end else if (ERR0 || ERR1) begin
      check("err_without_ack", {ERR1, ERR0}, 0);
    end
  end

  task automatic wait_acks(input int n);
    int got = 0;
    for (int i = 0; i < 400 && got < n; i++) begin
      @(negedge CLK);
      if (ACK0 || ACK1) got++;
    end
    check("ack_count", got, n);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_maddr"}, MADDR, 0);
    check({tag, "_mwdata"}, MWDATA, 0);
    check({tag, "_rdata0"}, RDATA0, 0);
    check({tag, "_rdata1"}, RDATA1, 0);
    check({tag, "_ctrl"}, {MWE, MSTART, ACK0, ACK1, ERR0, ERR1, BUSY}, 0);
  endtask

  task automatic txn(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input int d, input logic ovr, input logic [31:0] ovr_data,
                     input logic exp_err, input int lat);
    st_t s;
    ack_t a;
    logic [31:0] rd;
    mem_delay = d;
    mem_ovr = ovr;
    mem_ovr_data = ovr_data;
    s.addr = addr; s.we = we; s.wdata = wdata;
    st_q.push_back(s);
    if (!we && !exp_err) begin
      rd = ovr ? ovr_data : (addr ^ KEY);
      if (p != 0) m_rd1 = rd; else m_rd0 = rd;
    end
    a.port = p; a.err = exp_err; a.rd0 = m_rd0; a.rd1 = m_rd1; a.lat = lat;
    ack_q.push_back(a);
    if (p == 0) begin
      REQ0 = 1'b1; WE0 = we; ADDR0 = addr; WDATA0 = wdata;
    end else begin
      REQ1 = 1'b1; WE1 = we; ADDR1 = addr; WDATA1 = wdata;
    end
    wait_acks(1);
    REQ0 = 1'b0;
    REQ1 = 1'b0;
  endtask

  task automatic both(input int n, input logic [3:0] order, input logic [31:0] a0, input logic [31:0] a1);
    st_t s;
    ack_t a;
    logic [31:0] addr;
    for (int k = 0; k < n; k++) begin
      addr = order[k] ? a1 : a0;
      s.addr = addr; s.we = 1'b0; s.wdata = '0;
      st_q.push_back(s);
      if (order[k]) m_rd1 = addr ^ KEY; else m_rd0 = addr ^ KEY;
      a.port = order[k] ? 1 : 0; a.err = 1'b0; a.rd0 = m_rd0; a.rd1 = m_rd1; a.lat = 2;
      ack_q.push_back(a);
    end
    mem_delay = 1;
    mem_ovr = 1'b0;
    REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = a0; WDATA0 = '0;
    REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = a1; WDATA1 = '0;
    wait_acks(n);
    REQ0 = 1'b0;
    REQ1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    st_t s;
    bit seen;
    RST_N = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0; WE0 = 1'b0; WE1 = 1'b0;
    ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    RST_N = 1'b1;
    @(negedge CLK);

    txn(0, 1'b0, 32'h100, 32'h0, 2, 1'b1, 32'hDEADBEEF, 1'b0, 3);
    txn(1, 1'b1, 32'h40, 32'h12345678, 1, 1'b0, 32'h0, 1'b0, 2);
`ifdef ARB_FIXED_PRIO_EN
    both(4, 4'b1111, 32'h200, 32'h280);
`else
    both(4, 4'b1010, 32'h200, 32'h280);
`endif
    txn(0, 1'b0, 32'h500, 32'h0, 1000, 1'b0, 32'h0, 1'b1, TO + 1);
    txn(0, 1'b0, 32'h504, 32'h0, 1, 1'b0, 32'h0, 1'b0, 2);
    txn(1, 1'b0, 32'h700, 32'h0, TO + 1, 1'b0, 32'h0, 1'b1, TO + 1);
    txn(0, 1'b0, 32'h600, 32'h0, TO, 1'b0, 32'h0, 1'b0, TO + 1);

    // reset while port 1 sits in WAIT; the late MRDY must be ignored
    mem_delay = 3;
    mem_ovr = 1'b0;
    s.addr = 32'h300; s.we = 1'b0; s.wdata = '0;
    st_q.push_back(s);
    REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 32'h300; WDATA1 = '0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (MSTART) seen = 1'b1;
    end
    check("rst_mstart_seen", seen, 1);
    @(negedge CLK);
    RST_N = 1'b0;
    REQ1 = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    check_reset_outputs("wait_reset");
    m_rd0 = '0;
    m_rd1 = '0;
    repeat (4) @(negedge CLK);
    check("no_ack_after_reset", {ACK1, ACK0, BUSY}, 0);
`ifdef ARB_FIXED_PRIO_EN
    both(2, 4'b0011, 32'h800, 32'h880);
`else
    both(2, 4'b0010, 32'h800, 32'h880);
`endif

    repeat (4) @(negedge CLK);
    check("ack_queue_drained", ack_q.size(), 0);
    check("start_queue_drained", st_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
